// File: rtl/reg_wb_pkg.sv
// reg_wb_pkg: shared widths and the writeback entry type for reg_writeback and wb_fifo.
package reg_wb_pkg;
    localparam int XLEN       = 32;
    localparam int REG_ADDR_W = 5;

    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// wb_fifo: load-result FIFO whose entries can be squashed by destination register.
module wb_fifo import reg_wb_pkg::*; #(
    parameter int DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  push,
    input  wb_entry_t             push_entry,
    input  logic                  pop,
    input  logic                  squash_en,
    input  logic [REG_ADDR_W-1:0] squash_rd,
    output wb_entry_t             head,
    output logic                  full,
    output logic                  empty,
    output logic [31:0]           busy
);
    localparam int AW = $clog2(DEPTH);

    wb_entry_t         mem [DEPTH];
    logic [AW-1:0]     wptr;
    logic [AW-1:0]     rptr;
    logic [AW:0]       count;

    assign head  = mem[rptr];
    assign empty = count == '0;
    assign full  = count == (AW+1)'(DEPTH);

    // Valid bits are cleared on pop so busy can be taken over the whole array.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++)
                if (squash_en && mem[i].rd == squash_rd) mem[i].valid <= 1'b0;
            if (pop) begin
                mem[rptr].valid <= 1'b0;
                rptr            <= rptr + 1'b1;
            end
            if (push) begin
                mem[wptr] <= push_entry;
                wptr      <= wptr + 1'b1;
            end
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_comb begin
        busy = '0;
        for (int i = 0; i < DEPTH; i++)
            if (mem[i].valid) busy[mem[i].rd] = 1'b1;
        busy[0] = 1'b0;
    end
endmodule

// File: rtl/reg_writeback.sv
// reg_writeback: merges ALU and buffered LSU results into one register-file write port.
// Define WB_FORWARD_EN to add rs1/rs2 forwarding from the output register.
module reg_writeback import reg_wb_pkg::*; #(
    parameter int LSU_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  alu_valid,
    input  logic [REG_ADDR_W-1:0] alu_rd,
    input  logic [XLEN-1:0]       alu_data,
    input  logic                  lsu_valid,
    output logic                  lsu_ready,
    input  logic [REG_ADDR_W-1:0] lsu_rd,
    input  logic [XLEN-1:0]       lsu_data,
    output logic                  rd_en,
    output logic [REG_ADDR_W-1:0] rd_addr,
    output logic [XLEN-1:0]       rd_data,
`ifdef WB_FORWARD_EN
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    input  logic [REG_ADDR_W-1:0] rs2_addr,
    input  logic [XLEN-1:0]       rs1_file,
    input  logic [XLEN-1:0]       rs2_file,
    output logic [XLEN-1:0]       rs1_fwd,
    output logic [XLEN-1:0]       rs2_fwd,
`endif
    output logic [31:0]           busy_mask
);
    wb_entry_t   head;
    wb_entry_t   alu_entry;
    wb_entry_t   lsu_entry;
    wb_entry_t   nxt;
    wb_entry_t   out_q;
    logic        full;
    logic        empty;
    logic        lsu_fire;
    logic        alu_kill;
    logic        pop;
    logic        bypass;
    logic        push;
    logic [31:0] fifo_busy;

    assign lsu_ready = !full;
    assign lsu_fire  = lsu_valid && lsu_ready;
    assign alu_kill  = alu_valid && alu_rd != '0;
    assign pop       = !alu_valid && !empty;
    assign bypass    = !alu_valid && empty && lsu_fire;
    // A load overwritten by the younger ALU result in the same cycle is accepted but dropped.
    assign push      = lsu_fire && !bypass && !(alu_kill && lsu_rd == alu_rd);

    assign alu_entry = '{valid: alu_rd != '0, rd: alu_rd, data: alu_data};
    assign lsu_entry = '{valid: lsu_rd != '0, rd: lsu_rd, data: lsu_data};
    assign nxt       = alu_valid ? alu_entry : pop ? head : bypass ? lsu_entry : '0;

    wb_fifo #(.DEPTH(LSU_DEPTH)) u_fifo (
        .clk        (clk),
        .rst        (rst),
        .push       (push),
        .push_entry (lsu_entry),
        .pop        (pop),
        .squash_en  (alu_kill),
        .squash_rd  (alu_rd),
        .head       (head),
        .full       (full),
        .empty      (empty),
        .busy       (fifo_busy)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) out_q <= '0;
        else     out_q <= nxt;
    end

    assign rd_en   = out_q.valid;
    assign rd_addr = out_q.rd;
    assign rd_data = out_q.data;

`ifdef WB_FORWARD_EN
    assign rs1_fwd   = (rd_en && rd_addr == rs1_addr && rs1_addr != '0) ? rd_data : rs1_file;
    assign rs2_fwd   = (rd_en && rd_addr == rs2_addr && rs2_addr != '0) ? rd_data : rs2_file;
    assign busy_mask = fifo_busy;
`else
    assign busy_mask = fifo_busy | (rd_en ? 32'(1) << rd_addr : 32'd0);
`endif
endmodule

// File: tb/tb_reg_writeback.sv
// tb_reg_writeback: directed stimulus with a write scoreboard checked by an independent monitor.
module tb_reg_writeback;
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } exp_t;

`ifdef WB_FORWARD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        lsu_valid;
    logic        lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        rd_en;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] busy_mask;
`ifdef WB_FORWARD_EN
    logic [4:0]  rs1_addr = '0;
    logic [4:0]  rs2_addr = '0;
    logic [31:0] rs1_file = '0;
    logic [31:0] rs2_file = '0;
    logic [31:0] rs1_fwd;
    logic [31:0] rs2_fwd;
`endif

    int   checks = 0;
    int   errors = 0;
    exp_t exp_q[$];
    exp_t mon_e;

    reg_writeback dut (
        .clk       (clk),
        .rst       (rst),
        .alu_valid (alu_valid),
        .alu_rd    (alu_rd),
        .alu_data  (alu_data),
        .lsu_valid (lsu_valid),
        .lsu_ready (lsu_ready),
        .lsu_rd    (lsu_rd),
        .lsu_data  (lsu_data),
        .rd_en     (rd_en),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
`ifdef WB_FORWARD_EN
        .rs1_addr  (rs1_addr),
        .rs2_addr  (rs2_addr),
        .rs1_file  (rs1_file),
        .rs2_file  (rs2_file),
        .rs1_fwd   (rs1_fwd),
        .rs2_fwd   (rs2_fwd),
`endif
        .busy_mask (busy_mask)
    );

    always #5 clk = ~clk;

    // Every register-file write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (!rst && rd_en) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_write got x%0d=%h required no write", rd_addr, rd_data);
            end else begin
                mon_e = exp_q.pop_front();
                if (rd_addr !== mon_e.addr || rd_data !== mon_e.data) begin
                    errors++;
                    $display("FAIL write got x%0d=%h required x%0d=%h", rd_addr, rd_data, mon_e.addr, mon_e.data);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s got %h required %h", name, act, req);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic alu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        alu_valid = v;
        alu_rd    = rd;
        alu_data  = d;
    endtask

    task automatic lsu(input logic v, input logic [4:0] rd, input logic [31:0] d);
        lsu_valid = v;
        lsu_rd    = rd;
        lsu_data  = d;
    endtask

    task automatic expect_wr(input logic [4:0] a, input logic [31:0] d);
        exp_q.push_back('{addr: a, data: d});
    endtask

    function automatic logic [31:0] bit_of(input int r);
        return 32'(1) << r;
    endfunction

    function automatic logic [31:0] out_bit(input int r);
        return FWD ? 32'd0 : bit_of(r);
    endfunction

    initial begin
        rst = 1'b1;
        alu(1'b0, 5'd0, 32'd0);
        lsu(1'b0, 5'd0, 32'd0);
        #3;
        chk("reset_rd_en", 32'(rd_en), 32'd0);
        chk("reset_rd_addr", 32'(rd_addr), 32'd0);
        chk("reset_rd_data", rd_data, 32'd0);
        chk("reset_busy", busy_mask, 32'd0);
        chk("reset_ready", 32'(lsu_ready), 32'd1);
        step;
        step;
        rst = 1'b0;

        // Plain ALU write with one-cycle latency
        alu(1'b1, 5'd5, 32'h1234);
        expect_wr(5'd5, 32'h1234);
        step;
        alu(1'b0, 5'd0, 32'd0);
        chk("alu_busy", busy_mask, out_bit(5));
        step;
        chk("alu_busy_clear", busy_mask, 32'd0);

        // x0 destination is dropped
        alu(1'b1, 5'd0, 32'hFFFF);
        step;
        alu(1'b0, 5'd0, 32'd0);
        chk("x0_rd_en", 32'(rd_en), 32'd0);
        chk("x0_busy", busy_mask, 32'd0);
        step;

        // ALU priority fills the FIFO, then loads drain in order
        alu(1'b1, 5'd10, 32'h10A);
        lsu(1'b1, 5'd7, 32'h700);
        chk("fill_ready1", 32'(lsu_ready), 32'd1);
        expect_wr(5'd10, 32'h10A);
        step;
        alu(1'b1, 5'd11, 32'h10B);
        lsu(1'b1, 5'd8, 32'h800);
        chk("fill_ready2", 32'(lsu_ready), 32'd1);
        expect_wr(5'd11, 32'h10B);
        step;
        alu(1'b1, 5'd12, 32'h10C);
        lsu(1'b1, 5'd9, 32'h900);
        chk("full_ready", 32'(lsu_ready), 32'd0);
        chk("full_busy", busy_mask, bit_of(7) | bit_of(8) | out_bit(11));
        expect_wr(5'd12, 32'h10C);
        step;
        alu(1'b0, 5'd0, 32'd0);
        chk("full_ready_idle", 32'(lsu_ready), 32'd0);
        expect_wr(5'd7, 32'h700);
        step;
        chk("drain_ready", 32'(lsu_ready), 32'd1);
        expect_wr(5'd8, 32'h800);
        step;
        lsu(1'b0, 5'd0, 32'd0);
        expect_wr(5'd9, 32'h900);
        step;
        step;

        // Buffered load to x3 squashed by a younger ALU write to x3
        alu(1'b1, 5'd20, 32'h20);
        lsu(1'b1, 5'd3, 32'hAAAA);
        expect_wr(5'd20, 32'h20);
        step;
        alu(1'b1, 5'd3, 32'hBBBB);
        lsu(1'b0, 5'd0, 32'd0);
        chk("squash_busy_pre", busy_mask, bit_of(3) | out_bit(20));
        expect_wr(5'd3, 32'hBBBB);
        step;
        alu(1'b0, 5'd0, 32'd0);
        chk("squash_busy", busy_mask, out_bit(3));
        step;
        chk("squash_slot_rd_en", 32'(rd_en), 32'd0);
        chk("squash_slot_busy", busy_mask, 32'd0);

        // Same-cycle load to the ALU destination is accepted but dropped
        alu(1'b1, 5'd6, 32'h66);
        lsu(1'b1, 5'd6, 32'h99);
        chk("same_cycle_ready", 32'(lsu_ready), 32'd1);
        expect_wr(5'd6, 32'h66);
        step;
        alu(1'b0, 5'd0, 32'd0);
        lsu(1'b0, 5'd0, 32'd0);
        step;
        chk("same_cycle_drop", 32'(rd_en), 32'd0);

        // Empty FIFO: load bypasses straight to the output register
        lsu(1'b1, 5'd13, 32'hD00D);
        expect_wr(5'd13, 32'hD00D);
        step;
        lsu(1'b0, 5'd0, 32'd0);
        chk("bypass_rd_en", 32'(rd_en), 32'd1);
        step;

        // Reset while the FIFO holds two loads
        alu(1'b1, 5'd21, 32'h21);
        lsu(1'b1, 5'd14, 32'hE);
        expect_wr(5'd21, 32'h21);
        step;
        alu(1'b1, 5'd22, 32'h22);
        lsu(1'b1, 5'd15, 32'hF);
        step;
        alu(1'b0, 5'd0, 32'd0);
        lsu(1'b0, 5'd0, 32'd0);
        chk("prereset_ready", 32'(lsu_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("midreset_rd_en", 32'(rd_en), 32'd0);
        chk("midreset_busy", busy_mask, 32'd0);
        chk("midreset_ready", 32'(lsu_ready), 32'd1);
        step;
        rst = 1'b0;
        step;
        chk("postreset_rd_en", 32'(rd_en), 32'd0);
        step;
        step;

`ifdef WB_FORWARD_EN
        alu(1'b1, 5'd4, 32'h55);
        expect_wr(5'd4, 32'h55);
        step;
        alu(1'b0, 5'd0, 32'd0);
        rs1_addr = 5'd4;
        rs1_file = 32'h11;
        rs2_addr = 5'd0;
        rs2_file = 32'h22;
        #1;
        chk("fwd_rs1", rs1_fwd, 32'h55);
        chk("fwd_rs2", rs2_fwd, 32'h22);
        chk("fwd_busy", busy_mask, 32'd0);
        step;
        step;
`endif

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
